// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: request, response and data-RAM port bundle for the MEM-stage LSU
interface mem_stage_lsu_if #(parameter int ADDR_WIDTH = 5);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [4:0]            req_rd;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic [4:0]            rsp_rd;
  logic                  store_done;
  logic                  misalign;
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd, ram_rdata,
    output req_ready, ram_addr, ram_we, ram_wdata, rsp_valid, rsp_data, rsp_rd, store_done, misalign
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd, ram_rdata,
    input  req_ready, ram_addr, ram_we, ram_wdata, rsp_valid, rsp_data, rsp_rd, store_done, misalign
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with sub-word RMW stores and misalignment rejection
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mem_stage_lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD, ST_W, RMW_RD, RMW_WR} state_t;
  state_t state, nxt;
  logic                  accept, mis, uns_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [4:0]            rd_q, bsh;
  logic [DATA_WIDTH-1:0] wdata_q, merge_q, shifted, ld_val, lane_mask, lane_data;
  assign accept = bus.req_valid && bus.req_ready;
  assign mis = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  // Aligned accesses only reach the datapath, so one byte shift serves byte, half and word lanes.
  assign bsh       = {addr_q[1:0], 3'b000};
  assign shifted   = bus.ram_rdata >> bsh;
  assign ld_val    = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                     size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
  assign lane_mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << bsh;
  assign lane_data = (size_q == 2'b00 ? {24'b0, wdata_q[7:0]} : {16'b0, wdata_q[15:0]}) << bsh;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state == IDLE   ? (accept && !mis ? (!bus.req_we ? LD : bus.req_size == 2'b10 ? ST_W : RMW_RD) : IDLE) :
          state == RMW_RD ? RMW_WR : IDLE;
  end
  always_comb begin
    bus.req_ready = state == IDLE && !rst;
    bus.ram_we    = !rst && (state == ST_W || state == RMW_WR);
    bus.ram_wdata = state == RMW_WR ? merge_q : wdata_q;
    bus.ram_addr  = addr_q[ADDR_WIDTH+1:2];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      uns_q          <= 1'b0;
      size_q         <= 2'b00;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      merge_q        <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_rd     <= '0;
      bus.store_done <= 1'b0;
      bus.misalign   <= 1'b0;
    end else begin
      if (accept) begin
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rd_q    <= bus.req_rd;
      end
      if (state == LD) begin
        bus.rsp_data <= ld_val;
        bus.rsp_rd   <= rd_q;
      end
      if (state == RMW_RD) merge_q <= (bus.ram_rdata & ~lane_mask) | lane_data;
      bus.rsp_valid  <= state == LD;
      bus.store_done <= state == ST_W || state == RMW_WR;
      bus.misalign   <= accept && mis;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu with a behavioural word RAM
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_stage_lsu_if #(.ADDR_WIDTH(5)) bus();
  mem_stage_lsu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [32];
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.ram_we) we_cnt++;
  typedef struct {int kind; logic [31:0] data; logic [4:0] rd; int at;} exp_t;
  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Monitor: every output pulse must match the oldest outstanding expectation, on the right cycle.
  always @(negedge clk) begin : mon
    int k, got;
    exp_t e;
    if (!rst) begin
      k = int'(bus.rsp_valid) + int'(bus.store_done) + int'(bus.misalign);
      if (k > 1) check("exclusive_pulses", k, 1);
      if (k > 0) begin
        got = bus.rsp_valid ? 0 : bus.store_done ? 1 : 2;
        if (sb.size() == 0) check("unexpected_pulse", got + 10, 99);
        else begin
          e = sb.pop_front();
          check("pulse_kind", got, e.kind);
          check("pulse_cycle", cyc, e.at);
          if (got == 0) begin
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_rd", {27'b0, bus.rsp_rd}, {27'b0, e.rd});
          end
        end
      end
    end
  end
  // kind: 0 load response, 1 store_done, 2 misalign
  task automatic issue(input logic we, input logic [1:0] size, input logic uns, input logic [6:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int kind, input logic [31:0] exp_data);
    exp_t e;
    bit done;
    @(negedge clk);
    e.kind = kind;
    e.data = exp_data;
    e.rd   = rd;
    e.at   = cyc + (kind == 2 ? 1 : (kind == 1 && size != 2'b10) ? 3 : 2);
    sb.push_back(e);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    check("ready_at_issue", {31'b0, bus.req_ready}, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (kind == 2 && i == 0) check("ready_after_misalign", {31'b0, bus.req_ready}, 1);
      done = bus.req_ready;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask
  initial begin : stim
    int w0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_rd = '0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ram_we", {31'b0, bus.ram_we}, 0);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
      check("rst_store_done", {31'b0, bus.store_done}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, bus.req_ready}, 1);
    issue(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 0, 1, 0);
    check("ram_sw", mem[2], 32'hDEADBEEF);
    issue(0, 2'b10, 0, 7'h08, 0, 5'd7, 0, 32'hDEADBEEF);
    w0 = we_cnt;
    issue(1, 2'b00, 0, 7'h09, 32'h0000007F, 0, 1, 0);
    check("sb_one_write", we_cnt - w0, 1);
    check("ram_sb", mem[2], 32'hDEAD7FEF);
    issue(0, 2'b00, 0, 7'h0B, 0, 5'd3, 0, 32'hFFFFFFDE);
    issue(0, 2'b00, 1, 7'h0B, 0, 5'd4, 0, 32'h000000DE);
    issue(1, 2'b01, 0, 7'h0A, 32'h00001234, 0, 1, 0);
    check("ram_sh_hi", mem[2], 32'h12347FEF);
    issue(0, 2'b01, 0, 7'h08, 0, 5'd9, 0, 32'h00007FEF);
    issue(0, 2'b01, 0, 7'h0A, 0, 5'd10, 0, 32'h00001234);
    issue(1, 2'b01, 0, 7'h08, 32'h00008001, 0, 1, 0);
    check("ram_sh_lo", mem[2], 32'h12348001);
    issue(0, 2'b01, 0, 7'h08, 0, 5'd11, 0, 32'hFFFF8001);
    issue(0, 2'b01, 1, 7'h08, 0, 5'd31, 0, 32'h00008001);
    w0 = we_cnt;
    issue(0, 2'b10, 0, 7'h06, 0, 5'd1, 2, 0);
    issue(1, 2'b01, 0, 7'h05, 32'hFFFF, 0, 2, 0);
    issue(0, 2'b11, 0, 7'h08, 0, 5'd2, 2, 0);
    check("misalign_no_write", we_cnt - w0, 0);
    check("misalign_ram_kept", mem[2], 32'h12348001);
    issue(1, 2'b10, 0, 7'h10, 32'h11223344, 0, 1, 0);
    w0 = we_cnt;
    @(negedge clk);
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 7'h11;
    bus.req_wdata = 32'h000000AA;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rmw_we", {31'b0, bus.ram_we}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rmw_abort_idle", {31'b0, bus.req_ready}, 1);
    check("rmw_abort_no_write", we_cnt - w0, 0);
    check("rmw_abort_ram", mem[4], 32'h11223344);
    issue(0, 2'b10, 0, 7'h10, 0, 5'd12, 0, 32'h11223344);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
